// File: rtl/config_report_tx.sv
// config_report_tx: serialises a three-byte configuration report as back-to-back 8N1 UART frames.
// Each byte is {register index, value}, matching the encoding the host uses for writes.
module config_report_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       report_req,
    input  logic [3:0] mode,
    input  logic [3:0] brightness,
    input  logic [3:0] animation_sel,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [1:0]        byte_q, byte_d;
    logic [11:0]       snap_q, snap_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [7:0]        cur_byte;
    logic [2:0]        next_bit;
    logic              bit_end;

    // Byte being sent: index in the upper nibble, snapshotted value in the lower nibble.
    always_comb begin
        cur_byte = {2'b00, byte_q, snap_q[{byte_q, 2'b00} +: 4]};
        next_bit = bit_q + 3'd1;
        bit_end  = (baud_q == BaudMax);
    end

    // Next-state logic; tx is computed from the next state so the pin is glitch-free.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        snap_d  = snap_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            StIdle: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (report_req) begin
                    snap_d  = {animation_sel, brightness, mode};
                    state_d = StStart;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    byte_d  = 2'd0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = StData;
                    tx_d    = cur_byte[0];
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = next_bit;
                        tx_d  = cur_byte[next_bit];
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            StStop: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (byte_q == 2'd2) begin
                        state_d = StIdle;
                        byte_d  = 2'd0;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        // Next start bit follows the stop bit with no idle gap.
                        byte_d  = byte_q + 2'd1;
                        state_d = StStart;
                        tx_d    = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BaudW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            byte_q  <= 2'd0;
            snap_q  <= 12'h000;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            snap_q  <= snap_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_config_report_tx.sv
// Scoreboard bench for config_report_tx: stimulus pushes expected bytes and done cycles,
// negedge monitors decode the tx line and done/busy and compare against the queues.
module tb_config_report_tx;

    localparam int unsigned CPB = 4;

    logic       clk;
    logic       rst_n;
    logic       report_req;
    logic [3:0] mode;
    logic [3:0] brightness;
    logic [3:0] animation_sel;
    logic       tx;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [7:0] exp_bytes[$];
    int         exp_done[$];

    config_report_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .report_req   (report_req),
        .mode         (mode),
        .brightness   (brightness),
        .animation_sel(animation_sel),
        .tx           (tx),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests = tests + 1;
        fails = fails + 1;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Full 40-sample line pattern of one frame, sample 0 first.
    function automatic logic [39:0] frame_pat(input logic [7:0] b);
        logic [39:0] p;
        logic        v;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) v = 1'b0;
            else if (i == 9) v = 1'b1;
            else v = b[i-1];
            for (int j = 0; j < 4; j++) p[i*4+j] = v;
        end
        return p;
    endfunction

    // Frame monitor: records every cycle of a frame so bit widths are checked exactly.
    logic        in_frame = 1'b0;
    int          samp_cnt = 0;
    logic [39:0] samp;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && tx === 1'b0) begin
                in_frame = 1'b1;
                samp_cnt = 0;
            end
            if (in_frame) begin
                samp[samp_cnt] = tx;
                samp_cnt = samp_cnt + 1;
                if (samp_cnt == 40) begin
                    in_frame = 1'b0;
                    if (exp_bytes.size() == 0) fail_now("frame_unexpected");
                    else check("frame", samp, frame_pat(exp_bytes.pop_front()));
                end
            end
        end
    end

    // Done/busy monitor.
    int busy_run = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_run = 0;
        end else if (busy === 1'b1) begin
            busy_run = busy_run + 1;
        end else begin
            if (done === 1'b1) begin
                if (exp_done.size() == 0) begin
                    fail_now("done_unexpected");
                end else begin
                    check("done_cycle", cyc, exp_done.pop_front());
                    check("busy_len", busy_run, 120);
                end
            end
            busy_run = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_vals(input logic [3:0] m, input logic [3:0] b, input logic [3:0] a);
        mode = m;
        brightness = b;
        animation_sel = a;
    endtask

    task automatic push_report(input logic [3:0] m, input logic [3:0] b, input logic [3:0] a,
                               input int done_at);
        exp_bytes.push_back({4'h0, m});
        exp_bytes.push_back({4'h1, b});
        exp_bytes.push_back({4'h2, a});
        exp_done.push_back(done_at);
    endtask

    // One-cycle request at the current cycle N; returns in cycle N+1.
    task automatic request(input logic [3:0] m, input logic [3:0] b, input logic [3:0] a);
        set_vals(m, b, a);
        report_req = 1'b1;
        push_report(m, b, a, cyc + 121);
        step(1);
        report_req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (exp_bytes.size() == 0 && exp_done.size() == 0) break;
            step(1);
        end
        if (exp_bytes.size() != 0 || exp_done.size() != 0) fail_now("report_timeout");
        step(2);
    endtask

    initial begin
        rst_n = 1'b0;
        report_req = 1'b1;
        set_vals(4'h3, 4'hA, 4'h5);

        // Reset held with a pending request.
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("reset_tx", tx, 1'b1);
            check("reset_busy", busy, 1'b0);
            check("reset_done", done, 1'b0);
        end
        report_req = 1'b0;
        rst_n = 1'b1;
        step(3);
        check("idle_tx", tx, 1'b1);

        // Basic report.
        request(4'h3, 4'hA, 4'h5);
        check("start_latency_tx", tx, 1'b0);
        check("start_latency_busy", busy, 1'b1);
        wait_idle();

        // Snapshot: inputs change mid-report.
        request(4'h3, 4'hA, 4'h5);
        step(9);
        set_vals(4'h7, 4'h0, 4'h5);
        wait_idle();

        // Requests while busy are dropped.
        request(4'h3, 4'hA, 4'h5);
        step(19);
        report_req = 1'b1;
        step(1);
        report_req = 1'b0;
        step(79);
        report_req = 1'b1;
        step(1);
        report_req = 1'b0;
        wait_idle();
        step(20);
        check("post_busy_tx", tx, 1'b1);
        check("post_busy_busy", busy, 1'b0);

        // Held request: two reports, second accepted in the done cycle.
        set_vals(4'h9, 4'h4, 4'hC);
        report_req = 1'b1;
        push_report(4'h9, 4'h4, 4'hC, cyc + 121);
        push_report(4'h9, 4'h4, 4'hC, cyc + 242);
        step(200);
        report_req = 1'b0;
        wait_idle();

        // Abort mid-report with reset, then a clean report.
        request(4'h6, 4'h2, 4'hF);
        step(49);
        rst_n = 1'b0;
        exp_bytes.delete();
        exp_done.delete();
        step(1);
        check("abort_tx", tx, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        rst_n = 1'b1;
        step(150);
        check("abort_quiet_tx", tx, 1'b1);
        request(4'hE, 4'h1, 4'h8);
        wait_idle();

        check("bytes_drained", exp_bytes.size(), 0);
        check("done_drained", exp_done.size(), 0);
        check("final_tx", tx, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
